// File: rtl/voice_mixer.sv
// voice_mixer: snapshots per-voice phases on a sample tick, shares one sine ROM across
// the voices in turn, and emits the attenuated gated sum as one mono sample.
module voice_mixer #(
  parameter int NUM_VOICES  = 8,
  parameter int PHASE_W     = 32,
  parameter int LUT_ADDR_W  = 8,
  parameter int SAMPLE_W    = 16,
  parameter int ROM_LATENCY = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic                        sample_tick_in,
  input  logic [PHASE_W-1:0]          phase_value_in [0:NUM_VOICES-1],
  input  logic [NUM_VOICES-1:0]       gate_in,
  output logic [LUT_ADDR_W-1:0]       rom_addr_out,
  input  logic [SAMPLE_W-1:0]         rom_data_in,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_valid_out,
  output logic [$clog2(NUM_VOICES):0] active_count_out,
  output logic                        busy_out,
  output logic                        overrun_out
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam int ACC_W  = SAMPLE_W + VIDX_W;
  localparam int CNT_W  = VIDX_W + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUTPUT} state_t;

  state_t                    state;
  logic [VIDX_W-1:0]         v_idx;
  logic [VIDX_W-1:0]         v_nxt;
  logic                      v_last;
  logic [PHASE_W-1:0]        snap_phase [0:NUM_VOICES-1];
  logic [NUM_VOICES-1:0]     snap_gate;
  logic                      vld_p  [0:ROM_LATENCY];
  logic                      gate_p [0:ROM_LATENCY];
  logic                      last_p [0:ROM_LATENCY];
  logic signed [ACC_W-1:0]   acc;

  assign v_nxt  = v_idx + VIDX_W'(1);
  assign v_last = (v_idx == VIDX_W'(NUM_VOICES - 1));

  function automatic logic signed [ACC_W-1:0] sext(input logic [SAMPLE_W-1:0] d);
    return {{VIDX_W{d[SAMPLE_W-1]}}, d};
  endfunction

  // Divide by the voice count; arithmetic shift rounds toward -inf and cannot overflow.
  function automatic logic signed [SAMPLE_W-1:0] attenuate(input logic signed [ACC_W-1:0] a);
    logic signed [ACC_W-1:0] s;
    s = a >>> VIDX_W;
    return s[SAMPLE_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_VOICES-1:0] g);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_VOICES; i++) n = n + CNT_W'(g[i]);
    return n;
  endfunction

  // Snapshot stage: voice inputs are frozen for the whole sample
  always_ff @(posedge clk_in) begin
    if (state == IDLE && sample_tick_in) begin
      snap_phase <= phase_value_in;
      snap_gate  <= gate_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state            <= IDLE;
      busy_out         <= 1'b0;
      overrun_out      <= 1'b0;
      v_idx            <= '0;
      acc              <= '0;
      rom_addr_out     <= '0;
      sample_out       <= '0;
      sample_valid_out <= 1'b0;
      active_count_out <= '0;
      for (int i = 0; i <= ROM_LATENCY; i++) begin
        vld_p[i]  <= 1'b0;
        gate_p[i] <= 1'b0;
        last_p[i] <= 1'b0;
      end
    end else begin
      sample_valid_out <= 1'b0;
      vld_p[0]         <= 1'b0;
      gate_p[0]        <= 1'b0;
      last_p[0]        <= 1'b0;

      // ROM return stage: gate/last travel with the address for ROM_LATENCY cycles
      for (int i = 1; i <= ROM_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        gate_p[i] <= gate_p[i-1];
        last_p[i] <= last_p[i-1];
      end
      if (vld_p[ROM_LATENCY] && gate_p[ROM_LATENCY]) acc <= acc + sext(rom_data_in);

      if (sample_tick_in && state != IDLE) overrun_out <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick_in) begin
            v_idx        <= '0;
            acc          <= '0;
            rom_addr_out <= phase_value_in[0][PHASE_W-1 -: LUT_ADDR_W];
            vld_p[0]     <= 1'b1;
            gate_p[0]    <= gate_in[0];
            state        <= ISSUE;
            busy_out     <= 1'b1;
          end
        end
        // Issue stage: one ROM address per cycle, voice 0 was presented on entry
        ISSUE: begin
          if (!v_last) begin
            v_idx        <= v_nxt;
            rom_addr_out <= snap_phase[v_nxt][PHASE_W-1 -: LUT_ADDR_W];
            vld_p[0]     <= 1'b1;
            gate_p[0]    <= snap_gate[v_nxt];
            last_p[0]    <= (v_nxt == VIDX_W'(NUM_VOICES - 1));
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (vld_p[ROM_LATENCY] && last_p[ROM_LATENCY]) state <= OUTPUT;
        end
        // Output stage: results held until the next sample
        OUTPUT: begin
          sample_out       <= attenuate(acc);
          active_count_out <= popcount(snap_gate);
          sample_valid_out <= 1'b1;
          busy_out         <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer with a latency-2 programmable sine ROM model.
module tb_voice_mixer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        sample_tick_in;
  logic [31:0] phase [0:7];
  logic [7:0]  gate_in;
  logic [7:0]  rom_addr_out;
  logic [15:0] rom_data_in;
  logic [15:0] sample_out;
  logic        sample_valid_out;
  logic [3:0]  active_count_out;
  logic        busy_out;
  logic        overrun_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom_tab [0:255];
  logic [7:0]  ra_p1 = 8'h00;
  logic [7:0]  ra_p2 = 8'h00;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    ra_p1 <= rom_addr_out;
    ra_p2 <= ra_p1;
  end
  assign rom_data_in = rom_tab[ra_p2];

  voice_mixer dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .sample_tick_in   (sample_tick_in),
    .phase_value_in   (phase),
    .gate_in          (gate_in),
    .rom_addr_out     (rom_addr_out),
    .rom_data_in      (rom_data_in),
    .sample_out       (sample_out),
    .sample_valid_out (sample_valid_out),
    .active_count_out (active_count_out),
    .busy_out         (busy_out),
    .overrun_out      (overrun_out)
  );

  task automatic fill_rom(input logic [15:0] val);
    for (int i = 0; i < 256; i++) rom_tab[i] = val;
  endtask

  task automatic set_phases();
    for (int i = 0; i < 8; i++) phase[i] = 32'(i) << 24;
  endtask

  // Runs ncyc cycles from a tick in cycle 0; entered and left at posedge+1.
  task automatic run_frame(input int ncyc, input int t1, input int rst_c, input bit scramble,
                           output int vcnt, output int vfirst, output int vlast,
                           output logic [7:0] addr6, output logic busy11, output logic busy12);
    vcnt = 0; vfirst = -1; vlast = -1; addr6 = 'x; busy11 = 'x; busy12 = 'x;
    for (int c = 0; c < ncyc; c++) begin
      sample_tick_in = (c == 0) || (c == t1);
      rst_n_in       = (c == rst_c) ? 1'b0 : 1'b1;
      if (scramble && c == 1) begin
        gate_in = ~gate_in;
        for (int i = 0; i < 8; i++) phase[i] = 32'hDEAD_BEEF ^ 32'(i);
      end
      @(negedge clk_in);
      if (sample_valid_out) begin
        vcnt++;
        if (vfirst < 0) vfirst = c;
        vlast = c;
      end
      if (c == 6)  addr6  = rom_addr_out;
      if (c == 11) busy11 = busy_out;
      if (c == 12) busy12 = busy_out;
      @(posedge clk_in); #1;
    end
    sample_tick_in = 1'b0;
    rst_n_in       = 1'b1;
  endtask

  task automatic test_reset();
    rst_n_in = 1'b0;
    repeat (5) @(posedge clk_in);
    @(negedge clk_in);
    n_checks += 6;
    if (rom_addr_out !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h want 00", rom_addr_out); end
    if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL reset_sample: got %h want 0000", sample_out); end
    if (sample_valid_out !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", sample_valid_out); end
    if (active_count_out !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", active_count_out); end
    if (busy_out !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy_out); end
    if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun_out); end
    @(posedge clk_in); #1;
    rst_n_in = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
  endtask

  task automatic test_single_voice();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    fill_rom(16'h1111);
    rom_tab[8'h40] = 16'h7FFF;
    set_phases();
    phase[5] = 32'h4000_0000;
    gate_in  = 8'b0010_0000;
    run_frame(16, -1, -1, 1'b1, vc, vf, vl, a6, b11, b12);
    n_checks += 8;
    if (a6 !== 8'h40) begin n_fail++; $display("FAIL single_addr_c6: got %h want 40", a6); end
    if (vf !== 12) begin n_fail++; $display("FAIL single_latency: got %0d want 12", vf); end
    if (vc !== 1) begin n_fail++; $display("FAIL single_valid_count: got %0d want 1", vc); end
    if (sample_out !== 16'h0FFF) begin n_fail++; $display("FAIL single_sample: got %h want 0fff", sample_out); end
    if (active_count_out !== 4'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", active_count_out); end
    if (b11 !== 1'b1) begin n_fail++; $display("FAIL single_busy11: got %b want 1", b11); end
    if (b12 !== 1'b0) begin n_fail++; $display("FAIL single_busy12: got %b want 0", b12); end
    if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL single_overrun: got %b want 0", overrun_out); end
  endtask

  task automatic test_full_scale();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    set_phases();
    gate_in = 8'hFF;
    fill_rom(16'h8000);
    run_frame(16, -1, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 3;
    if (sample_out !== 16'h8000) begin n_fail++; $display("FAIL neg_full_sample: got %h want 8000", sample_out); end
    if (active_count_out !== 4'd8) begin n_fail++; $display("FAIL neg_full_count: got %0d want 8", active_count_out); end
    if (vf !== 12) begin n_fail++; $display("FAIL neg_full_latency: got %0d want 12", vf); end
    fill_rom(16'h7FFF);
    run_frame(16, -1, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 2;
    if (sample_out !== 16'h7FFF) begin n_fail++; $display("FAIL pos_full_sample: got %h want 7fff", sample_out); end
    if (active_count_out !== 4'd8) begin n_fail++; $display("FAIL pos_full_count: got %0d want 8", active_count_out); end
  endtask

  task automatic test_all_off();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    set_phases();
    gate_in = 8'h00;
    fill_rom(16'h1234);
    run_frame(16, -1, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 4;
    if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL off_sample: got %h want 0000", sample_out); end
    if (active_count_out !== 4'd0) begin n_fail++; $display("FAIL off_count: got %0d want 0", active_count_out); end
    if (vf !== 12) begin n_fail++; $display("FAIL off_latency: got %0d want 12", vf); end
    if (vc !== 1) begin n_fail++; $display("FAIL off_valid_count: got %0d want 1", vc); end
  endtask

  // -3 + 0 = -3, divided by 8 toward -inf is -1
  task automatic test_rounding();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    fill_rom(16'h0000);
    set_phases();
    phase[0] = 32'h1000_0000;
    phase[1] = 32'h2000_0000;
    rom_tab[8'h10] = 16'hFFFD;
    gate_in = 8'b0000_0011;
    run_frame(16, -1, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 2;
    if (sample_out !== 16'hFFFF) begin n_fail++; $display("FAIL round_sample: got %h want ffff", sample_out); end
    if (active_count_out !== 4'd2) begin n_fail++; $display("FAIL round_count: got %0d want 2", active_count_out); end
  endtask

  task automatic test_overrun();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    set_phases();
    gate_in = 8'hFF;
    fill_rom(16'h0800);
    run_frame(16, 5, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 4;
    if (vc !== 1) begin n_fail++; $display("FAIL ovr_valid_count: got %0d want 1", vc); end
    if (vf !== 12) begin n_fail++; $display("FAIL ovr_latency: got %0d want 12", vf); end
    if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b want 1", overrun_out); end
    if (sample_out !== 16'h0800) begin n_fail++; $display("FAIL ovr_sample: got %h want 0800", sample_out); end
  endtask

  task automatic test_back_to_back();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    run_frame(26, 12, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 4;
    if (vc !== 2) begin n_fail++; $display("FAIL b2b_valid_count: got %0d want 2", vc); end
    if (vf !== 12) begin n_fail++; $display("FAIL b2b_first: got %0d want 12", vf); end
    if (vl !== 24) begin n_fail++; $display("FAIL b2b_second: got %0d want 24", vl); end
    if (overrun_out !== 1'b1) begin n_fail++; $display("FAIL b2b_overrun_sticky: got %b want 1", overrun_out); end
  endtask

  task automatic test_reset_mid();
    int vc, vf, vl; logic [7:0] a6; logic b11, b12;
    run_frame(16, -1, 6, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 6;
    if (vc !== 0) begin n_fail++; $display("FAIL rst_mid_valid_count: got %0d want 0", vc); end
    if (sample_out !== 16'h0000) begin n_fail++; $display("FAIL rst_mid_sample: got %h want 0000", sample_out); end
    if (active_count_out !== 4'd0) begin n_fail++; $display("FAIL rst_mid_count: got %0d want 0", active_count_out); end
    if (busy_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b want 0", busy_out); end
    if (overrun_out !== 1'b0) begin n_fail++; $display("FAIL rst_mid_overrun: got %b want 0", overrun_out); end
    if (rom_addr_out !== 8'h00) begin n_fail++; $display("FAIL rst_mid_addr: got %h want 00", rom_addr_out); end
    run_frame(16, -1, -1, 1'b0, vc, vf, vl, a6, b11, b12);
    n_checks += 3;
    if (vf !== 12) begin n_fail++; $display("FAIL rst_after_latency: got %0d want 12", vf); end
    if (sample_out !== 16'h0800) begin n_fail++; $display("FAIL rst_after_sample: got %h want 0800", sample_out); end
    if (active_count_out !== 4'd8) begin n_fail++; $display("FAIL rst_after_count: got %0d want 8", active_count_out); end
  endtask

  initial begin
    rst_n_in       = 1'b0;
    sample_tick_in = 1'b0;
    gate_in        = 8'h00;
    set_phases();
    fill_rom(16'h0000);
    test_reset();
    test_single_voice();
    test_full_scale();
    test_all_off();
    test_rounding();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
